// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, FSM encoding
// and the bit positions of the packed status flags.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_NOR    = 4'd5;
    localparam logic [3:0] ALU_NOT    = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRL    = 4'd8;
    localparam logic [3:0] ALU_SRA    = 4'd9;
    localparam logic [3:0] ALU_INC    = 4'd10;
    localparam logic [3:0] ALU_DEC    = 4'd11;
    localparam logic [3:0] ALU_SLT    = 4'd12;
    localparam logic [3:0] ALU_SGT    = 4'd13;
    localparam logic [3:0] ALU_LUI    = 4'd14;
    localparam logic [3:0] ALU_POPCNT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_W     = 3;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU functions with carry/borrow and signed-overflow generation.
// Shift and popcount codes produce zero here; the sequencer handles them.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_func,
    output logic [N-1:0] o_res,
    output logic         o_carry,
    output logic         o_ovf
);

    logic [N-1:0] w_opb;
    logic [N:0]   w_sum;
    logic         w_sub;
    logic         w_arith;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_opb   = (i_func == ALU_INC || i_func == ALU_DEC) ? N'(1) : i_b;
        w_sub   = (i_func == ALU_SUB || i_func == ALU_DEC);
        w_arith = (i_func == ALU_ADD || i_func == ALU_SUB ||
                   i_func == ALU_INC || i_func == ALU_DEC);
        // Bit N of the widened difference is the unsigned borrow.
        w_sum   = w_sub ? ({1'b0, i_a} - {1'b0, w_opb})
                        : ({1'b0, i_a} + {1'b0, w_opb});
        o_carry = w_arith & w_sum[N];
        o_ovf   = w_arith
                & (w_sub ? (i_a[N-1] != w_opb[N-1]) : (i_a[N-1] == w_opb[N-1]))
                & (w_sum[N-1] != i_a[N-1]);

        o_res = '0;
        case (i_func)
            ALU_ADD, ALU_SUB,
            ALU_INC, ALU_DEC: o_res = w_sum[N-1:0];
            ALU_AND:          o_res = i_a & i_b;
            ALU_OR:           o_res = i_a | i_b;
            ALU_XOR:          o_res = i_a ^ i_b;
            ALU_NOR:          o_res = ~(i_a | i_b);
            ALU_NOT:          o_res = ~i_a;
            ALU_SLT:          o_res = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SGT:          o_res = {{(N-1){1'b0}}, ($signed(i_a) > $signed(i_b))};
            ALU_LUI:          o_res = {i_a[N/2-1:0], {(N/2){1'b0}}};
            default:          o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready on both sides, iterative shifter and popcount,
// registered result and flags held in DONE until the consumer takes them.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   func,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] RES,
    output logic         zero,
    output logic         carry,
    output logic         ovf,
    output logic         busy
);

    localparam int SHW   = $clog2(N);
    localparam int CNT_W = SHW + 1;

    state_t              r_state, w_next_state;
    logic [3:0]          r_op;
    logic [N-1:0]        r_work;
    logic [N-1:0]        r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [N-1:0]        r_res;
    logic [FLAG_W-1:0]   r_flags;

    logic [N-1:0]        w_core_res;
    logic                w_core_carry, w_core_ovf;
    logic [SHW-1:0]      w_amt;
    logic                w_accept, w_is_shift, w_last;
    logic [N-1:0]        w_shift_step, w_acc_next;
    logic                w_load;
    logic [N-1:0]        w_load_res;
    logic                w_load_carry, w_load_ovf;

    alu_comb_core #(.N(N)) u_core (
        .i_a     (A),
        .i_b     (B),
        .i_func  (func),
        .o_res   (w_core_res),
        .o_carry (w_core_carry),
        .o_ovf   (w_core_ovf)
    );

    assign w_amt      = B[SHW-1:0];
    assign w_accept   = in_valid && (r_state == ST_IDLE);
    assign w_is_shift = (func == ALU_SLL || func == ALU_SRL || func == ALU_SRA);
    assign w_last     = (r_cnt == CNT_W'(1));
    assign w_acc_next = r_acc + N'(r_work[0]);

    always_comb begin
        case (r_op)
            ALU_SLL: w_shift_step = {r_work[N-2:0], 1'b0};
            ALU_SRA: w_shift_step = {r_work[N-1], r_work[N-1:1]};
            default: w_shift_step = {1'b0, r_work[N-1:1]};
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift)
                        w_next_state = (w_amt == '0) ? ST_DONE : ST_SHIFT;
                    else if (func == ALU_POPCNT)
                        w_next_state = ST_COUNT;
                    else
                        w_next_state = ST_DONE;
                end
            end
            ST_SHIFT: if (w_last)    w_next_state = ST_DONE;
            ST_COUNT: if (w_last)    w_next_state = ST_DONE;
            ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // Result write-back happens exactly once per operation, on entry to DONE.
    always_comb begin
        w_load       = 1'b0;
        w_load_res   = w_core_res;
        w_load_carry = 1'b0;
        w_load_ovf   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_shift && w_amt == '0) begin
                    w_load     = 1'b1;
                    w_load_res = A;
                end else if (w_accept && !w_is_shift && func != ALU_POPCNT) begin
                    w_load       = 1'b1;
                    w_load_carry = w_core_carry;
                    w_load_ovf   = w_core_ovf;
                end
            end
            ST_SHIFT: begin
                w_load     = w_last;
                w_load_res = w_shift_step;
            end
            ST_COUNT: begin
                w_load     = w_last;
                w_load_res = w_acc_next;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_work  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= func;
                        r_work <= A;
                        r_acc  <= '0;
                        r_cnt  <= w_is_shift ? {1'b0, w_amt} : CNT_W'(N);
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_shift_step;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                ST_COUNT: begin
                    r_work <= {1'b0, r_work[N-1:1]};
                    r_acc  <= w_acc_next;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase

            if (w_load) begin
                r_res               <= w_load_res;
                r_flags[FLAG_ZERO]  <= (w_load_res == '0);
                r_flags[FLAG_CARRY] <= w_load_carry;
                r_flags[FLAG_OVF]   <= w_load_ovf;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign RES       = r_res;
    assign zero      = r_flags[FLAG_ZERO];
    assign carry     = r_flags[FLAG_CARRY];
    assign ovf       = r_flags[FLAG_OVF];

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (N=32): directed cases, randomized ops
// against an arithmetic reference model, backpressure and mid-op reset.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic         in_ready, out_valid, zero, carry, ovf, busy;
    logic [N-1:0] A, B, RES;
    logic [3:0]   func;

    int checks   = 0;
    int failures = 0;

    alu_mc #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RES       (RES),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c, output logic v,
                                  output int lat);
        longint          sa, sb, sfull;
        longint unsigned ua, ub;
        longint          smax, smin;
        logic signed [31:0] as32;
        int amt;
        smax = 64'sd2147483647;
        smin = -smax - 1;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        as32 = a;
        amt  = int'(b[4:0]);
        r = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (f)
            ALU_ADD: begin
                sfull = sa + sb; r = 32'(ua + ub);
                c = ((ua + ub) >> 32) != 0; v = (sfull > smax) || (sfull < smin);
            end
            ALU_SUB: begin
                sfull = sa - sb; r = 32'(ua - ub);
                c = ua < ub; v = (sfull > smax) || (sfull < smin);
            end
            ALU_INC: begin
                sfull = sa + 1; r = 32'(ua + 1);
                c = ((ua + 1) >> 32) != 0; v = sfull > smax;
            end
            ALU_DEC: begin
                sfull = sa - 1; r = 32'(ua - 1);
                c = (a == 0); v = sfull < smin;
            end
            ALU_AND:    r = a & b;
            ALU_OR:     r = a | b;
            ALU_XOR:    r = a ^ b;
            ALU_NOR:    r = ~(a | b);
            ALU_NOT:    r = ~a;
            ALU_SLL:    begin r = a << amt;     lat = 1 + amt; end
            ALU_SRL:    begin r = a >> amt;     lat = 1 + amt; end
            ALU_SRA:    begin r = as32 >>> amt; lat = 1 + amt; end
            ALU_SLT:    r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SGT:    r = (sa > sb) ? 32'd1 : 32'd0;
            ALU_LUI:    r = {a[15:0], 16'h0};
            ALU_POPCNT: begin r = 32'($countones(a)); lat = 1 + N; end
            default:    r = '0;
        endcase
    endfunction

    // Issue one op, check latency/result/flags, hold backpressure, then pop.
    task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic        ec, ev;
        int          elat, lat;
        model(f, a, b, er, ec, ev, elat);

        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1; A = a; B = b; func = f;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; func = 4'($urandom);

        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency f=%0d", f), lat, elat);
        check($sformatf("RES f=%0d a=%08h b=%08h", f, a, b), RES, er);
        check($sformatf("zero f=%0d", f), zero, (er == 0));
        check($sformatf("carry f=%0d", f), carry, ec);
        check($sformatf("ovf f=%0d", f), ovf, ev);
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 1);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("RES_held", RES, er);
            check("out_valid_held", out_valid, 1);
            check("in_ready_held_low", in_ready, 0);
        end

        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_pop", out_valid, 0);
        check("in_ready_after_pop", in_ready, 1);
        check("busy_after_pop", busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_RES"}, RES, 0);
        check({tag, "_zero"}, zero, 0);
        check({tag, "_carry"}, carry, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic seen_valid;
        logic [3:0]  rf;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; func = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(ALU_SUB, 32'h8000_0000, 32'h1, 0);
        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(ALU_SGT, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(ALU_SRA, 32'h8000_0000, 32'h1F, 0);
        run_op(ALU_SRA, 32'h8000_0000, 32'h20, 0);
        run_op(ALU_SLL, 32'h0000_0001, 32'h1F, 0);
        run_op(ALU_SRL, 32'h8000_0000, 32'h4, 0);
        run_op(ALU_POPCNT, 32'hF0F0_F0F1, 32'h0, 0);
        run_op(ALU_POPCNT, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(ALU_INC, 32'h7FFF_FFFF, 32'h0, 0);
        run_op(ALU_DEC, 32'h0000_0000, 32'h0, 0);
        run_op(ALU_LUI, 32'h1234_ABCD, 32'h0, 0);
        run_op(ALU_OR, 32'h0000_1234, 32'h0, 5);

        // Randomized ops with occasional corner operands
        for (int n = 0; n < 40; n++) begin
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = ra;
                default: ;
            endcase
            run_op(rf, ra, rb, $urandom_range(0, 2));
        end

        // Reset during COUNT aborts the operation
        @(negedge clk);
        in_valid = 1'b1; A = 32'hF0F0_F0F1; B = '0; func = ALU_POPCNT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("no_out_valid_after_abort", seen_valid, 0);
        check("RES_after_abort", RES, 0);
        run_op(ALU_ADD, 32'd2, 32'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU with a valid/ready handshake on both sides, registered result and status flags. It implements the same 16-entry function set as the team's combinational ALU. Shifts now take a full shift amount instead of one bit, and popcount runs iteratively, so arbitrary widths close timing. The block sits between the operand-fetch stage and the writeback stage of the datapath.

## Interface
- N, 32: datapath width; power of two, ≥ 8
- SHW, $clog2(N): derived local; shift-amount width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/func presented
- in_ready  out  1  block can accept; high only in IDLE
- A, B  in  N  operands; two's complement where signed
- func  in  4  operation select
- out_valid  out  1  RES/flags valid
- out_ready  in  1  consumer takes result
- RES  out  N  result
- zero  out  1  RES == 0
- carry  out  1  carry-out (add/inc) or borrow (sub/dec)
- ovf  out  1  signed overflow (add/sub/inc/dec)
- busy  out  1  state ≠ IDLE

## Operation
- func: 0 A+B, 1 A−B, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 ~A, 7 SLL, 8 SRL, 9 SRA, 10 A+1, 11 A−1, 12 SLT, 13 SGT, 14 LUI, 15 POPCNT.
- Shift amount is B[SHW-1:0]; upper bits of B are ignored.
- SLT/SGT compare A and B as signed values. RES = {N-1 zeros, result bit}.
- LUI: RES = {A[N/2-1:0], N/2 zeros}.
- POPCNT: RES is the count of ones in A, zero-extended.
- Arithmetic wraps modulo 2^N.
  - carry = carry-out for ops 0 and 10; borrow for ops 1 and 11 (unsigned A<B, and A==0 for dec). Otherwise 0.
  - ovf = signed overflow for ops 0, 1, 10, 11. Otherwise 0.
  - zero is evaluated on the final RES for every op.
- FSM states: IDLE, SHIFT, COUNT, DONE.
  - IDLE, on accept (in_valid & in_ready): ops 0–6 and 10–14 compute and register → DONE. Shift with amount 0 → DONE with RES = A. Shift with amount ≠ 0 → SHIFT: load A, counter = amount. POPCNT → COUNT: load A, acc = 0, counter = N.
  - SHIFT: shift one position per cycle (SRA replicates the MSB), decrement counter. When counter reaches 1 → DONE.
  - COUNT: add the LSB to acc, shift right, decrement counter. After the N-th step → DONE.
  - DONE: out_valid = 1; RES and flags are held stable. On out_ready → IDLE.
- Operands and func are captured on accept. Input changes afterwards have no effect.

## Timing
- Reset values: state IDLE, RES 0, zero 0, carry 0, ovf 0, out_valid 0, in_ready 1, busy 0.
- Latency is measured from the accept edge t0:
  - single-cycle ops and shift by 0: out_valid at t0+1
  - shift by s: out_valid at t0+1+s
  - POPCNT: out_valid at t0+1+N
- out_valid stays high until the edge where out_ready is sampled high. If out_ready is already high at t0+1, the handshake completes that cycle.
- in_ready is low from t0+1 until the cycle after the output handshake. There is no same-cycle output-pop/input-accept, so the minimum initiation interval is 2 cycles.
- rst mid-operation aborts the operation the next edge: no out_valid and no partial RES. rst wins over any simultaneous handshake.
- in_valid while busy is ignored. The producer must hold it high.

## Structure
- Package alu_pkg holds:
  - func localparams (ALU_ADD … ALU_POPCNT)
  - FSM state encoding
  - flag bit positions
- Sub-module alu_comb_core(N) holds the single-cycle ops and their flag generation. It is purely combinational and is instantiated once.
- The FSM, shift/count datapath and output registers live in alu_mc.

## Test plan
- N=32, ADD A=0xFFFFFFFF, B=1 → RES 0, zero 1, carry 1, ovf 0 at t0+1.
- SUB A=0x80000000, B=1 → RES 0x7FFFFFFF, ovf 1, carry 0. SLT A=−1, B=1 → RES 1.
- SRA A=0x80000000, B=0x1F → RES 0xFFFFFFFF at t0+32. B=0x20 (amount 0) → RES = A at t0+1.
- POPCNT A=0xF0F0F0F1 → RES 17, out_valid exactly at t0+33.
- Hold out_ready low 5 cycles with RES=0x1234 → RES stable and in_ready low throughout. Raise out_ready → IDLE next edge, in_ready high.
- rst during COUNT at t0+10 → out_valid never rises, all outputs at reset values. A new ADD 2+3 accepted after reset → RES 5.
